// File: rtl/cart_sdram_arbiter_if.sv
// SDRAM single-command port bundle between cart_sdram_arbiter and the SDRAM controller.
//   master (arbiter):  drives sdr_addr, sdr_din, sdr_we, sdr_rd; samples sdr_dout, sdr_ready
//   slave  (sdram):    samples the command signals; drives sdr_dout, sdr_ready
interface cart_sdram_arbiter_if #(
   parameter int AW = 25
);
   logic [AW-1:0] sdr_addr;
   logic [7:0]    sdr_din;
   logic          sdr_we;
   logic          sdr_rd;
   logic [7:0]    sdr_dout;
   logic          sdr_ready;

   modport master (
      output sdr_addr, sdr_din, sdr_we, sdr_rd,
      input  sdr_dout, sdr_ready
   );

   modport slave (
      input  sdr_addr, sdr_din, sdr_we, sdr_rd,
      output sdr_dout, sdr_ready
   );
endinterface

// File: rtl/cart_sdram_arbiter.sv
// cart_sdram_arbiter
//   Shares the single-command SDRAM port between the HPS ROM download byte
//   stream (buffered in a small write FIFO) and console cartridge reads.
//   One SDRAM command is in flight at a time; read data returns on cart_d_o
//   with a one-cycle cart_valid_o strobe.
// Ports
//   clk_sys, reset      clock, synchronous active-high reset
//   dl_*_i / dl_full_o  download byte stream in, FIFO full back-pressure
//   cart_rd_i, cart_a_i cartridge read strobe and byte address
//   cart_d_o, cart_valid_o, cart_busy_o  read data, completion strobe, busy
//   err_timeout_o       sticky: FIFO overflow or command abort
//   sdr                 SDRAM command port (cart_sdram_arbiter_if.master)
// Optional build macro
//   READ_CACHE_EN       one-entry read cache answering repeat reads next cycle
//
// state      | meaning
// S_IDLE     | waiting for sdr_ready, then pick write or read by priority
// S_ISSUE_WR | sdr_we pulse with FIFO head, pop FIFO
// S_ISSUE_RD | sdr_rd pulse with pending read address
// S_WAIT_LO  | waiting for SDRAM to drop ready (command accepted)
// S_WAIT_HI  | waiting for SDRAM to raise ready (command complete)
module cart_sdram_arbiter #(
   parameter int AW         = 25,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic                   dl_active_i,
   input  logic                   dl_wr_i,
   input  logic [AW-1:0]          dl_addr_i,
   input  logic [7:0]             dl_data_i,
   output logic                   dl_full_o,
   input  logic                   cart_rd_i,
   input  logic [19:0]            cart_a_i,
   output logic [7:0]             cart_d_o,
   output logic                   cart_valid_o,
   output logic                   cart_busy_o,
   output logic                   err_timeout_o,
   cart_sdram_arbiter_if.master   sdr
);
   localparam int PW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE_WR, S_ISSUE_RD, S_WAIT_LO, S_WAIT_HI} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [7:0]    fifo_data_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [19:0]   rd_addr_q;
   logic          rd_pend_q;
   logic          cur_rd_q, cur_rd_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [AW-1:0] addr_q, addr_out;
   logic [7:0]    din_q, din_out;
   logic [7:0]    cart_d_q;
   logic          cart_valid_q;
   logic          err_q;
   logic          we_out, rd_out, done, abort;
   logic          full, empty, push, drop, pop, wr_sel, busy, hit;

   assign full  = (count_q == CW'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign push  = dl_wr_i & ~full;
   assign drop  = dl_wr_i & full;
   assign pop   = (state_q == S_ISSUE_WR);
   // During a download the FIFO wins; otherwise a pending read wins.
   assign wr_sel = ~empty & (dl_active_i | ~rd_pend_q);
   assign busy   = rd_pend_q | (cur_rd_q & (state_q != S_IDLE));

   always_comb begin
      state_d  = state_q;
      cur_rd_d = cur_rd_q;
      tmr_d    = tmr_q;
      addr_out = addr_q;
      din_out  = din_q;
      we_out   = 1'b0;
      rd_out   = 1'b0;
      done     = 1'b0;
      abort    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sdr.sdr_ready) begin
               if (wr_sel) begin
                  state_d  = S_ISSUE_WR;
                  cur_rd_d = 1'b0;
               end else if (rd_pend_q) begin
                  state_d  = S_ISSUE_RD;
                  cur_rd_d = 1'b1;
               end
            end
         end
         S_ISSUE_WR: begin
            we_out   = 1'b1;
            addr_out = fifo_addr_q[rd_ptr_q];
            din_out  = fifo_data_q[rd_ptr_q];
            tmr_d    = TW'(TIMEOUT);
            state_d  = S_WAIT_LO;
         end
         S_ISSUE_RD: begin
            rd_out   = 1'b1;
            addr_out = AW'(rd_addr_q);
            tmr_d    = TW'(TIMEOUT);
            state_d  = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (tmr_q == '0) begin
               abort   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q - 1'b1;
               if (!sdr.sdr_ready) state_d = S_WAIT_HI;
            end
         end
         S_WAIT_HI: begin
            if (sdr.sdr_ready) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end else if (tmr_q == '0) begin
               abort   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef READ_CACHE_EN
   logic [19:0] tag_q;
   logic        tag_v_q;
   logic [7:0]  cache_data_q;

   // Only answer from the cache when no read is queued or in flight, so a
   // hit can never collide with an SDRAM completion.
   assign hit = cart_rd_i & tag_v_q & (tag_q == cart_a_i) & ~busy;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         tag_q        <= '0;
         tag_v_q      <= 1'b0;
         cache_data_q <= '0;
      end else if (push) begin
         tag_v_q <= 1'b0;
      end else if (done && cur_rd_q) begin
         tag_q        <= addr_q[19:0];
         tag_v_q      <= 1'b1;
         cache_data_q <= sdr.sdr_dout;
      end
   end
`else
   assign hit = 1'b0;
`endif

   always_ff @(posedge clk_sys) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= dl_addr_i;
         fifo_data_q[wr_ptr_q] <= dl_data_i;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         rd_addr_q    <= '0;
         rd_pend_q    <= 1'b0;
         cur_rd_q     <= 1'b0;
         tmr_q        <= '0;
         addr_q       <= '0;
         din_q        <= '0;
         cart_d_q     <= '0;
         cart_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_rd_q <= cur_rd_d;
         tmr_q    <= tmr_d;
         addr_q   <= addr_out;
         din_q    <= din_out;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         // A new request always takes the latest address; if the previous
         // read is already on the bus this queues one reissue.
         if (cart_rd_i && !hit) begin
            rd_addr_q <= cart_a_i;
            rd_pend_q <= 1'b1;
         end else if (state_q == S_ISSUE_RD) begin
            rd_pend_q <= 1'b0;
         end
         cart_valid_q <= (done & cur_rd_q) | hit;
         if (done && cur_rd_q) cart_d_q <= sdr.sdr_dout;
`ifdef READ_CACHE_EN
         else if (hit) cart_d_q <= cache_data_q;
`endif
         err_q <= err_q | drop | abort;
      end
   end

   assign dl_full_o     = full;
   assign cart_d_o      = cart_d_q;
   assign cart_valid_o  = cart_valid_q;
   assign cart_busy_o   = busy;
   assign err_timeout_o = err_q;
   assign sdr.sdr_addr  = addr_out;
   assign sdr.sdr_din   = din_out;
   assign sdr.sdr_we    = we_out;
   assign sdr.sdr_rd    = rd_out;
endmodule

// File: tb/tb_cart_sdram_arbiter.sv
module tb_cart_sdram_arbiter;
   localparam int AW      = 25;
   localparam int TIMEOUT = 255;

   logic          clk_sys = 1'b0;
   logic          reset;
   logic          dl_active, dl_wr, dl_full;
   logic [AW-1:0] dl_addr;
   logic [7:0]    dl_data;
   logic          cart_rd, cart_valid, cart_busy, err_timeout;
   logic [19:0]   cart_a;
   logic [7:0]    cart_d;

   int tests  = 0;
   int errors = 0;

   cart_sdram_arbiter_if #(.AW(AW)) sif ();

   cart_sdram_arbiter #(.AW(AW), .FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .dl_active_i  (dl_active),
      .dl_wr_i      (dl_wr),
      .dl_addr_i    (dl_addr),
      .dl_data_i    (dl_data),
      .dl_full_o    (dl_full),
      .cart_rd_i    (cart_rd),
      .cart_a_i     (cart_a),
      .cart_d_o     (cart_d),
      .cart_valid_o (cart_valid),
      .cart_busy_o  (cart_busy),
      .err_timeout_o(err_timeout),
      .sdr          (sif.master)
   );

   always #5 clk_sys = ~clk_sys;

   // SDRAM model: drops ready on a command, raises it lat cycles later with
   // read data = addr[7:0] ^ 8'h91. hold forces ready low; stuck freezes it.
   logic          m_rdy;
   logic [7:0]    m_dout;
   logic [AW-1:0] m_rd_addr;
   int            m_cnt;
   int            lat = 10;
   bit            hold = 1'b0, stuck = 1'b0;
   logic [AW-1:0] wr_addr_log [$];
   logic [7:0]    wr_data_log [$];
   int            rd_cmds = 0;
   bit            both_hi = 1'b0;

   assign sif.sdr_ready = m_rdy & ~hold;
   assign sif.sdr_dout  = m_dout;

   always @(posedge clk_sys) begin
      if (reset) begin
         m_rdy     <= 1'b1;
         m_cnt     <= 0;
         m_dout    <= 8'h00;
         m_rd_addr <= '0;
      end else if (sif.sdr_we || sif.sdr_rd) begin
         m_rdy <= 1'b0;
         m_cnt <= lat;
         if (sif.sdr_rd) m_rd_addr <= sif.sdr_addr;
      end else if (m_cnt > 0 && !stuck) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_rdy  <= 1'b1;
            m_dout <= m_rd_addr[7:0] ^ 8'h91;
         end
      end
   end

   always @(posedge clk_sys) begin
      if (!reset) begin
         if (sif.sdr_we) begin
            wr_addr_log.push_back(sif.sdr_addr);
            wr_data_log.push_back(sif.sdr_din);
         end
         if (sif.sdr_rd) rd_cmds++;
         if (sif.sdr_we && sif.sdr_rd) both_hi = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
      cart_rd = 1'b0; cart_a = '0; hold = 1'b0; stuck = 1'b0; lat = 10;
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (sif.sdr_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", sif.sdr_we); end
      tests++; if (sif.sdr_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", sif.sdr_rd); end
      tests++; if (cart_d !== 8'h00) begin errors++; $display("FAIL reset_cart_d: got %h want 00", cart_d); end
      tests++; if (dl_full !== 1'b0) begin errors++; $display("FAIL reset_dl_full: got %b want 0", dl_full); end
      tests++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_timeout); end
      tests++; if (cart_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", cart_busy); end
      // reset in the middle of a read
      cart_a = 20'h00321; cart_rd = 1'b1; tick(); cart_rd = 1'b0;
      repeat (4) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      tests++; if (cart_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", cart_busy); end
      tests++; if (sif.sdr_rd !== 1'b0) begin errors++; $display("FAIL midreset_rd: got %b want 0", sif.sdr_rd); end
   endtask

   task automatic test_burst();
      int base, n;
      do_reset();
      dl_active = 1'b1; hold = 1'b1;
      base = wr_addr_log.size();
      for (int i = 0; i < 6; i++) begin
         dl_wr = 1'b1; dl_addr = AW'(32'h100 + i); dl_data = 8'h10 + 8'(i);
         tick();
         tests++;
         if (dl_full !== (i >= 3)) begin errors++; $display("FAIL burst_full[%0d]: got %b want %b", i, dl_full, (i >= 3)); end
      end
      dl_wr = 1'b0;
      tests++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL burst_overflow_err: got %b want 1", err_timeout); end
      hold = 1'b0;
      n = 0;
      while ((wr_addr_log.size() - base) < 4 && n < 300) begin tick(); n++; end
      repeat (30) tick();
      tests++;
      if (wr_addr_log.size() - base != 4) begin
         errors++; $display("FAIL burst_write_count: got %0d want 4", wr_addr_log.size() - base);
      end else begin
         for (int j = 0; j < 4; j++) begin
            tests++;
            if (wr_addr_log[base+j] !== AW'(32'h100 + j) || wr_data_log[base+j] !== 8'h10 + 8'(j)) begin
               errors++;
               $display("FAIL burst_write[%0d]: got %h/%h want %h/%h", j, wr_addr_log[base+j],
                        wr_data_log[base+j], AW'(32'h100 + j), 8'h10 + 8'(j));
            end
         end
      end
      tests++; if (dl_full !== 1'b0) begin errors++; $display("FAIL burst_drained_full: got %b want 0", dl_full); end
      dl_active = 1'b0;
   endtask

   task automatic test_read();
      int n;
      do_reset();
      lat = 3;
      cart_a = 20'h0_1234; cart_rd = 1'b1;
      tick(); cart_rd = 1'b0;
      tests++; if (sif.sdr_rd !== 1'b0) begin errors++; $display("FAIL read_early: got %b want 0", sif.sdr_rd); end
      tests++; if (cart_busy !== 1'b1) begin errors++; $display("FAIL read_busy: got %b want 1", cart_busy); end
      tick();
      tests++; if (sif.sdr_rd !== 1'b1) begin errors++; $display("FAIL read_issue: got %b want 1", sif.sdr_rd); end
      tests++; if (sif.sdr_addr !== 25'h0001234) begin errors++; $display("FAIL read_addr: got %h want 0001234", sif.sdr_addr); end
      n = 0;
      while (!cart_valid && n < 50) begin tick(); n++; end
      tests++; if (cart_valid !== 1'b1) begin errors++; $display("FAIL read_valid: got %b want 1", cart_valid); end
      tests++; if (cart_d !== 8'hA5) begin errors++; $display("FAIL read_data: got %h want a5", cart_d); end
      tick();
      tests++; if (cart_valid !== 1'b0) begin errors++; $display("FAIL read_valid_pulse: got %b want 0", cart_valid); end
      tests++; if (cart_busy !== 1'b0) begin errors++; $display("FAIL read_done_busy: got %b want 0", cart_busy); end
   endtask

   task automatic test_priority(input bit act);
      int n, base;
      bit first_we;
      do_reset();
      lat = 3; hold = 1'b1; dl_active = act;
      base = wr_addr_log.size();
      dl_wr = 1'b1; dl_addr = 25'h200; dl_data = 8'h5A;
      cart_a = 20'h00777; cart_rd = 1'b1;
      tick(); dl_wr = 1'b0; cart_rd = 1'b0;
      tick(); tick();
      hold = 1'b0;
      n = 0;
      while (!(sif.sdr_we || sif.sdr_rd) && n < 20) begin tick(); n++; end
      first_we = sif.sdr_we;
      tests++; if (first_we !== act) begin errors++; $display("FAIL prio_first_we[act=%0d]: got %b want %b", act, first_we, act); end
      n = 0;
      while (!cart_valid && n < 100) begin tick(); n++; end
      tests++; if (cart_d !== 8'hE6 || cart_valid !== 1'b1) begin errors++; $display("FAIL prio_read[act=%0d]: got %h/%b want e6/1", act, cart_d, cart_valid); end
      repeat (20) tick();
      tests++;
      if (wr_addr_log.size() - base != 1 || wr_addr_log[base] !== 25'h200 || wr_data_log[base] !== 8'h5A) begin
         errors++; $display("FAIL prio_write[act=%0d]: got %0d writes want 1 at 200/5a", act, wr_addr_log.size() - base);
      end
      dl_active = 1'b0;
   endtask

   task automatic test_timeout();
      int n;
      bit saw_valid;
      do_reset();
      lat = 3; stuck = 1'b1;
      cart_a = 20'h00ABC; cart_rd = 1'b1; tick(); cart_rd = 1'b0;
      n = 0;
      while (!sif.sdr_rd && n < 10) begin tick(); n++; end
      n = 0; saw_valid = 1'b0;
      while (!err_timeout && n < 400) begin
         tick(); n++;
         if (cart_valid) saw_valid = 1'b1;
      end
      tests++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err_timeout); end
      tests++; if (n < TIMEOUT || n > TIMEOUT + 3) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d..%0d", n, TIMEOUT, TIMEOUT + 3); end
      tests++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL timeout_no_valid: got %b want 0", saw_valid); end
      tests++; if (cart_busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got %b want 0", cart_busy); end
      stuck = 1'b0;
      cart_a = 20'h00456; cart_rd = 1'b1; tick(); cart_rd = 1'b0;
      n = 0;
      while (!cart_valid && n < 50) begin tick(); n++; end
      tests++; if (cart_valid !== 1'b1 || cart_d !== 8'hC7) begin errors++; $display("FAIL timeout_recover: got %h/%b want c7/1", cart_d, cart_valid); end
      tests++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", err_timeout); end
   endtask

   task automatic test_cache();
      int n, rd_base;
      do_reset();
      lat = 3;
      cart_a = 20'h00010; cart_rd = 1'b1; tick(); cart_rd = 1'b0;
      n = 0;
      while (!cart_valid && n < 50) begin tick(); n++; end
      tests++; if (cart_d !== 8'h81) begin errors++; $display("FAIL cache_first: got %h want 81", cart_d); end
      tick();
      rd_base = rd_cmds;
      cart_rd = 1'b1; tick(); cart_rd = 1'b0;
`ifdef READ_CACHE_EN
      tests++; if (cart_valid !== 1'b1 || cart_d !== 8'h81) begin errors++; $display("FAIL cache_hit: got %h/%b want 81/1", cart_d, cart_valid); end
      repeat (10) tick();
      tests++; if (rd_cmds != rd_base) begin errors++; $display("FAIL cache_no_sdr_rd: got %0d reads want 0", rd_cmds - rd_base); end
      dl_active = 1'b1; dl_wr = 1'b1; dl_addr = 25'h10; dl_data = 8'h33;
      tick(); dl_wr = 1'b0;
      repeat (20) tick();
      dl_active = 1'b0;
      rd_base = rd_cmds;
      cart_rd = 1'b1; tick(); cart_rd = 1'b0;
      tests++; if (cart_valid !== 1'b0) begin errors++; $display("FAIL cache_inval_early: got %b want 0", cart_valid); end
`else
      tests++; if (cart_valid !== 1'b0) begin errors++; $display("FAIL nocache_early: got %b want 0", cart_valid); end
`endif
      n = 0;
      while (!cart_valid && n < 50) begin tick(); n++; end
      tests++; if (cart_valid !== 1'b1 || cart_d !== 8'h81) begin errors++; $display("FAIL cache_reread: got %h/%b want 81/1", cart_d, cart_valid); end
      tests++; if (rd_cmds != rd_base + 1) begin errors++; $display("FAIL cache_reread_sdr: got %0d reads want 1", rd_cmds - rd_base); end
   endtask

   initial begin
      test_reset();
      test_burst();
      test_read();
      test_priority(1'b1);
      test_priority(1'b0);
      test_timeout();
      test_cache();
      tests++; if (both_hi !== 1'b0) begin errors++; $display("FAIL we_rd_exclusive: got %b want 0", both_hi); end
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
